bus_arbiter: RTL

Two-master, one-slave memory bus arbiter that shares the single 16-bit memory port between the `dcpu` core (master 0) and a secondary requester such as DMA or debug (master 1). It arbitrates per transaction with round-robin priority and passes the cs/we/addr/dat/ack handshake through to the granted master. A timeout counter terminates transactions the slave never acknowledges and flags an error to the owning master.

---
 rtl/dcpu_pkg.sv | 19 +
 rtl/bus_arbiter_if.sv | 60 ++++++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dcpu_pkg.sv
// dcpu_pkg: shared definitions for the dcpu memory-bus arbiter.
//   W            data/address width of the memory port
//   arb_state_e  arbiter states; GNTx encodings are one-hot, matching o_grant
//   GRANT_*      one-hot owner codes driven on o_grant
package dcpu_pkg;

   localparam int unsigned W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } arb_state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: the two master ports, the slave port and the grant
// indicator of the dcpu memory-bus arbiter.
//   i_mx_*   master x request: cs, we, addr, write data
//   o_mx_*   master x response: read data, ack, err
//   o_s_*    slave request: cs, we, addr, write data
//   i_s_*    slave response: read data, ack
//   o_grant  one-hot current owner
// Modports:
//   slave   the arbiter's view; it serves both masters
//   master  the environment's view (masters plus memory)
interface bus_arbiter_if #(
   parameter int unsigned W = dcpu_pkg::W
) ();

   logic         i_m0_cs;
   logic         i_m0_we;
   logic [W-1:0] i_m0_addr;
   logic [W-1:0] i_m0_dat;
   logic [W-1:0] o_m0_dat;
   logic         o_m0_ack;
   logic         o_m0_err;

   logic         i_m1_cs;
   logic         i_m1_we;
   logic [W-1:0] i_m1_addr;
   logic [W-1:0] i_m1_dat;
   logic [W-1:0] o_m1_dat;
   logic         o_m1_ack;
   logic         o_m1_err;

   logic         o_s_cs;
   logic         o_s_we;
   logic [W-1:0] o_s_addr;
   logic [W-1:0] o_s_dat;
   logic [W-1:0] i_s_dat;
   logic         i_s_ack;

   logic [1:0]   o_grant;

   modport slave (
      input  i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
      input  i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
      input  i_s_dat, i_s_ack,
      output o_m0_dat, o_m0_ack, o_m0_err,
      output o_m1_dat, o_m1_ack, o_m1_err,
      output o_s_cs, o_s_we, o_s_addr, o_s_dat,
      output o_grant
   );

   modport master (
      output i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
      output i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
      output i_s_dat, i_s_ack,
      input  o_m0_dat, o_m0_ack, o_m0_err,
      input  o_m1_dat, o_m1_ack, o_m1_err,
      input  o_s_cs, o_s_we, o_s_addr, o_s_dat,
      input  o_grant
   );

endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave memory-bus arbiter with per-transaction
// round-robin priority and a slave-ack timeout.
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        bus_arbiter_if.slave: master 0 (dcpu), master 1 (DMA/debug),
//              slave memory port and the one-hot o_grant
// Parameters: W data/address width, TOW timeout counter width,
// TIMEOUT granted cycles without ack before forced termination (1..2^TOW-1).
module bus_arbiter
   import dcpu_pkg::*;
#(
   parameter int unsigned W       = dcpu_pkg::W,
   parameter int unsigned TOW     = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   bus_arbiter_if.slave   bus
);

   arb_state_e     state_q, state_d;
   logic           last_q, last_d;  // last master granted: 0 = M0, 1 = M1
   logic [TOW-1:0] to_q, to_d;

   logic           term;            // timeout terminal count this cycle
   logic           s_cs, s_we;
   logic [W-1:0]   s_addr, s_dat;
   logic           m0_ack, m0_err, m1_ack, m1_err;
   logic [1:0]     grant;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;  // M0 wins the first tie
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      to_d    = to_q;
      s_cs    = 1'b0;
      s_we    = 1'b0;
      s_addr  = '0;
      s_dat   = '0;
      m0_ack  = 1'b0;
      m0_err  = 1'b0;
      m1_ack  = 1'b0;
      m1_err  = 1'b0;
      grant   = GRANT_NONE;
      term    = (to_q == TOW'(TIMEOUT - 1));

      unique case (state_q)
         IDLE: begin
            to_d = '0;
            if (bus.i_m0_cs && bus.i_m1_cs) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (bus.i_m0_cs) begin
               state_d = GNT0;
            end else if (bus.i_m1_cs) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            grant  = GRANT_M0;
            s_cs   = bus.i_m0_cs;
            s_we   = bus.i_m0_we;
            s_addr = bus.i_m0_addr;
            s_dat  = bus.i_m0_dat;
            if (!bus.i_m0_cs) begin
               // Abort: no ack, round-robin history untouched.
               state_d = IDLE;
               to_d    = '0;
            end else if (bus.i_s_ack || term) begin
               // A real ack beats a coincident timeout.
               m0_ack  = 1'b1;
               m0_err  = !bus.i_s_ack;
               last_d  = 1'b0;
               state_d = bus.i_m1_cs ? GNT1 : IDLE;
               to_d    = '0;
            end else begin
               to_d = to_q + TOW'(1);
            end
         end
         GNT1: begin
            grant  = GRANT_M1;
            s_cs   = bus.i_m1_cs;
            s_we   = bus.i_m1_we;
            s_addr = bus.i_m1_addr;
            s_dat  = bus.i_m1_dat;
            if (!bus.i_m1_cs) begin
               state_d = IDLE;
               to_d    = '0;
            end else if (bus.i_s_ack || term) begin
               m1_ack  = 1'b1;
               m1_err  = !bus.i_s_ack;
               last_d  = 1'b1;
               state_d = bus.i_m0_cs ? GNT0 : IDLE;
               to_d    = '0;
            end else begin
               to_d = to_q + TOW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            to_d    = '0;
         end
      endcase
   end

   assign bus.o_s_cs   = s_cs;
   assign bus.o_s_we   = s_we;
   assign bus.o_s_addr = s_addr;
   assign bus.o_s_dat  = s_dat;
   assign bus.o_m0_dat = bus.i_s_dat;
   assign bus.o_m1_dat = bus.i_s_dat;
   assign bus.o_m0_ack = m0_ack;
   assign bus.o_m0_err = m0_err;
   assign bus.o_m1_ack = m1_ack;
   assign bus.o_m1_err = m1_err;
   assign bus.o_grant  = grant;

endmodule
